// File: rtl/ctrl_txn_profiler.sv
// ---------------------------------------------------------------------------
// ctrl_txn_profiler
//
// Watches one HLS module's ap_ctrl handshake plus the iteration events of its
// pipelined loop. For every transaction it measures start cycle, inclusive
// start-to-done latency, iter_end count and pipe_stall cycles, then pushes one
// record into a small first-word-fall-through FIFO that a slower consumer
// drains over a valid/ready stream.
//
// Optional build macro: CTRL_TXN_PROFILER_II_EN
//   When defined, each record also carries the min/max initiation interval
//   (cycles between consecutive iter_start pulses) seen in the transaction.
//   When undefined, those ports do not exist and iter_start is ignored.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   ap_start/ap_done/ap_continue  observed ap_ctrl handshake
//   iter_start/iter_end   loop iteration qualifiers
//   pipe_stall            loop pipeline blocked this cycle
//   rec_valid/rec_ready   record stream handshake
//   rec_id, rec_start_cyc, rec_latency, rec_iters, rec_stalls  record fields
//   rec_min_ii, rec_max_ii  (optional) initiation interval extremes
//   busy                  transaction in progress (RUN or HOLD)
//   overflow              sticky, a record was dropped on a full FIFO
//   drop_cnt              saturating count of dropped records
// ---------------------------------------------------------------------------
module ctrl_txn_profiler #(
  parameter int CNT_W      = 32,
  parameter int ID_W       = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             iter_start,
  input  logic             iter_end,
  input  logic             pipe_stall,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [ID_W-1:0]  rec_id,
  output logic [CNT_W-1:0] rec_start_cyc,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_iters,
  output logic [CNT_W-1:0] rec_stalls,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt
`ifdef CTRL_TXN_PROFILER_II_EN
  ,
  output logic [CNT_W-1:0] rec_min_ii,
  output logic [CNT_W-1:0] rec_max_ii
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ID_W-1:0]  ID_ONE  = {{(ID_W-1){1'b0}}, 1'b1};
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + CNT_ONE;
    return v;
  endfunction

  state_t state, state_next;

  logic [CNT_W-1:0] cyc;
  logic [ID_W-1:0]  next_id;
  logic [CNT_W-1:0] start_cyc, start_cyc_n;
  logic [CNT_W-1:0] lat, lat_n;
  logic [CNT_W-1:0] iters, iters_n;
  logic [CNT_W-1:0] stalls, stalls_n;
  logic             complete;

  // FIFO storage, one array per record field
  logic [ID_W-1:0]  mem_id    [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_start [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_lat   [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_iters [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_stall [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic             empty, full, pop, push_ok, drop;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state plus next accumulator values. The accumulator "_n" values
  // already include this cycle's events, so on completion they are exactly
  // the record contents.
  always_comb begin
    state_next  = state;
    complete    = 1'b0;
    start_cyc_n = start_cyc;
    lat_n       = lat;
    iters_n     = iters;
    stalls_n    = stalls;
    case (state)
      IDLE: begin
        if (ap_start) begin
          start_cyc_n = cyc;
          lat_n       = CNT_ONE;
          iters_n     = iter_end   ? CNT_ONE : '0;
          stalls_n    = pipe_stall ? CNT_ONE : '0;
          if (ap_done && ap_continue) complete   = 1'b1;
          else                        state_next = RUN;
        end
      end
      RUN: begin
        lat_n    = sat_inc(lat, 1'b1);
        iters_n  = sat_inc(iters, iter_end);
        stalls_n = sat_inc(stalls, pipe_stall);
        if (ap_done) begin
          complete   = 1'b1;
          state_next = ap_continue ? IDLE : HOLD;
        end
      end
      HOLD: begin
        // ap_start in the releasing cycle is deliberately not seen; a new
        // transaction can only begin once we are back in IDLE.
        if (ap_continue) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO status. A push into a full FIFO is still accepted when the head is
  // popped in the same cycle, since the slot frees at the same edge.
  assign wr_idx  = wr_ptr[AW-1:0];
  assign rd_idx  = rd_ptr[AW-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign pop     = !empty && rec_ready;
  assign push_ok = complete && (!full || pop);
  assign drop    = complete && full && !pop;

  // Counters, accumulators, FIFO pointers and drop tracking
  always_ff @(posedge clock) begin
    if (reset) begin
      cyc       <= '0;
      next_id   <= '0;
      start_cyc <= '0;
      lat       <= '0;
      iters     <= '0;
      stalls    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      cyc       <= cyc + CNT_ONE;
      start_cyc <= start_cyc_n;
      lat       <= lat_n;
      iters     <= iters_n;
      stalls    <= stalls_n;
      if (complete) next_id <= next_id + ID_ONE;
      if (push_ok)  wr_ptr  <= wr_ptr + PTR_ONE;
      if (pop)      rd_ptr  <= rd_ptr + PTR_ONE;
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc(drop_cnt, 1'b1);
      end
    end
  end

  // Record storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (!reset && push_ok) begin
      mem_id[wr_idx]    <= next_id;
      mem_start[wr_idx] <= start_cyc_n;
      mem_lat[wr_idx]   <= lat_n;
      mem_iters[wr_idx] <= iters_n;
      mem_stall[wr_idx] <= stalls_n;
    end
  end

  // Fields read as zero while empty so stale storage is never exposed.
  assign rec_valid     = !empty;
  assign rec_id        = empty ? '0 : mem_id[rd_idx];
  assign rec_start_cyc = empty ? '0 : mem_start[rd_idx];
  assign rec_latency   = empty ? '0 : mem_lat[rd_idx];
  assign rec_iters     = empty ? '0 : mem_iters[rd_idx];
  assign rec_stalls    = empty ? '0 : mem_stall[rd_idx];
  assign busy          = (state != IDLE);

`ifdef CTRL_TXN_PROFILER_II_EN
  logic [CNT_W-1:0] last_is, last_is_n;
  logic [CNT_W-1:0] min_ii, min_ii_n, max_ii, max_ii_n, ii;
  logic             seen_is, seen_is_n;
  logic [CNT_W-1:0] mem_min [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_max [FIFO_DEPTH];

  // Interval tracking: the first iter_start only timestamps; every later one
  // measures the gap from the previous pulse. Accumulates only in the start
  // cycle and in RUN, matching the other per-transaction counters.
  always_comb begin
    last_is_n = last_is;
    min_ii_n  = min_ii;
    max_ii_n  = max_ii;
    seen_is_n = seen_is;
    ii        = cyc - last_is;
    if (state == IDLE && ap_start) begin
      min_ii_n  = '1;
      max_ii_n  = '0;
      seen_is_n = iter_start;
      last_is_n = cyc;
    end else if (state == RUN && iter_start) begin
      if (seen_is) begin
        if (ii < min_ii) min_ii_n = ii;
        if (ii > max_ii) max_ii_n = ii;
      end
      seen_is_n = 1'b1;
      last_is_n = cyc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_is <= '0;
      min_ii  <= '1;
      max_ii  <= '0;
      seen_is <= 1'b0;
    end else begin
      last_is <= last_is_n;
      min_ii  <= min_ii_n;
      max_ii  <= max_ii_n;
      seen_is <= seen_is_n;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push_ok) begin
      mem_min[wr_idx] <= min_ii_n;
      mem_max[wr_idx] <= max_ii_n;
    end
  end

  assign rec_min_ii = empty ? '0 : mem_min[rd_idx];
  assign rec_max_ii = empty ? '0 : mem_max[rd_idx];
`else
  // iter_start only feeds the interval feature, which is not built here.
  logic unused_iter_start;
  assign unused_iter_start = iter_start;
`endif

endmodule

// File: tb/tb_ctrl_txn_profiler.sv
// ---------------------------------------------------------------------------
// tb_ctrl_txn_profiler
//
// Directed bench for ctrl_txn_profiler with default parameters. Cycle N is
// the clock interval in which the DUT cycle counter holds N; inputs for that
// cycle are driven 1 time unit after the previous rising edge and outputs are
// inspected at the same point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_ctrl_txn_profiler;

  logic        clock;
  logic        reset;
  logic        ap_start, ap_done, ap_continue;
  logic        iter_start, iter_end, pipe_stall;
  logic        rec_valid, rec_ready;
  logic [15:0] rec_id;
  logic [31:0] rec_start_cyc, rec_latency, rec_iters, rec_stalls;
  logic        busy, overflow;
  logic [31:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  ctrl_txn_profiler dut (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_done(ap_done), .ap_continue(ap_continue),
    .iter_start(iter_start), .iter_end(iter_end), .pipe_stall(pipe_stall),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_id(rec_id), .rec_start_cyc(rec_start_cyc), .rec_latency(rec_latency),
    .rec_iters(rec_iters), .rec_stalls(rec_stalls),
    .busy(busy), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to the next cycle
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Two reset edges; returns positioned in cycle 0 with all inputs idle
  task automatic do_reset();
    reset = 1'b1;
    ap_start = 1'b0; ap_done = 1'b0; ap_continue = 1'b1;
    iter_start = 1'b0; iter_end = 1'b0; pipe_stall = 1'b0;
    rec_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Everything reads as zero right after reset
  task automatic test_reset();
    do_reset();
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0d expected 0", rec_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0d expected 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %0d expected 0", overflow); end
    checks++; if (drop_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    checks++; if (rec_latency !== 32'd0) begin errors++; $display("[TB] FAIL reset_latency: got %0d expected 0", rec_latency); end
  endtask

  // Start at 5, done at 14, 8 iter_end pulses, 2 stall cycles
  task automatic test_basic();
    do_reset();
    repeat (5) tick();
    for (int c = 5; c <= 14; c++) begin
      ap_start   = (c == 5);
      ap_done    = (c == 14);
      iter_end   = (c >= 6 && c <= 13);
      pipe_stall = (c == 8 || c == 9);
      checks++; if (busy !== (c != 5)) begin errors++; $display("[TB] FAIL basic_busy_c%0d: got %0d expected %0d", c, busy, (c != 5)); end
      if (c == 14) begin
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_early: got %0d expected 0", rec_valid); end
      end
      tick();
    end
    ap_start = 1'b0; ap_done = 1'b0; iter_end = 1'b0; pipe_stall = 1'b0;
    checks++; if (rec_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %0d expected 1", rec_valid); end
    checks++; if (rec_id !== 16'd0) begin errors++; $display("[TB] FAIL basic_id: got %0d expected 0", rec_id); end
    checks++; if (rec_start_cyc !== 32'd5) begin errors++; $display("[TB] FAIL basic_start: got %0d expected 5", rec_start_cyc); end
    checks++; if (rec_latency !== 32'd10) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 10", rec_latency); end
    checks++; if (rec_iters !== 32'd8) begin errors++; $display("[TB] FAIL basic_iters: got %0d expected 8", rec_iters); end
    checks++; if (rec_stalls !== 32'd2) begin errors++; $display("[TB] FAIL basic_stalls: got %0d expected 2", rec_stalls); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_after: got %0d expected 0", busy); end
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drained: got %0d expected 0", rec_valid); end
  endtask

  // ap_start and ap_done together in IDLE at cycle 3
  task automatic test_start_done_same();
    do_reset();
    repeat (3) tick();
    ap_start = 1'b1; ap_done = 1'b1;
    tick();
    ap_start = 1'b0; ap_done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL same_busy: got %0d expected 0", busy); end
    checks++; if (rec_valid !== 1'b1) begin errors++; $display("[TB] FAIL same_valid: got %0d expected 1", rec_valid); end
    checks++; if (rec_start_cyc !== 32'd3) begin errors++; $display("[TB] FAIL same_start: got %0d expected 3", rec_start_cyc); end
    checks++; if (rec_latency !== 32'd1) begin errors++; $display("[TB] FAIL same_latency: got %0d expected 1", rec_latency); end
    checks++; if (rec_iters !== 32'd0) begin errors++; $display("[TB] FAIL same_iters: got %0d expected 0", rec_iters); end
  endtask

  // Four 4-cycle transactions with ap_start held high, starts at 0,4,8,12
  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      ap_start = 1'b1;
      ap_done  = ((c % 4) == 3);
      checks++; if (busy !== ((c % 4) != 0)) begin errors++; $display("[TB] FAIL b2b_busy_c%0d: got %0d expected %0d", c, busy, ((c % 4) != 0)); end
      tick();
    end
    ap_start = 1'b0; ap_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rec_id !== 16'(i)) begin errors++; $display("[TB] FAIL b2b_id%0d: got %0d expected %0d", i, rec_id, i); end
      checks++; if (rec_start_cyc !== 32'(4 * i)) begin errors++; $display("[TB] FAIL b2b_start%0d: got %0d expected %0d", i, rec_start_cyc, 4 * i); end
      checks++; if (rec_latency !== 32'd4) begin errors++; $display("[TB] FAIL b2b_latency%0d: got %0d expected 4", i, rec_latency); end
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;
    end
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_empty: got %0d expected 0", rec_valid); end
  endtask

  // Ten 2-cycle transactions into an unread 8-entry FIFO, then drain
  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0; ap_done = 1'b1;
      tick();
      ap_done = 1'b0;
      if (k == 7) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: got %0d expected 0", overflow); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %0d expected 1", overflow); end
    checks++; if (drop_cnt !== 32'd2) begin errors++; $display("[TB] FAIL ovf_drop_cnt: got %0d expected 2", drop_cnt); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rec_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovf_valid%0d: got %0d expected 1", i, rec_valid); end
      checks++; if (rec_id !== 16'(i)) begin errors++; $display("[TB] FAIL ovf_id%0d: got %0d expected %0d", i, rec_id, i); end
      checks++; if (rec_start_cyc !== 32'(2 * i)) begin errors++; $display("[TB] FAIL ovf_start%0d: got %0d expected %0d", i, rec_start_cyc, 2 * i); end
      checks++; if (rec_latency !== 32'd2) begin errors++; $display("[TB] FAIL ovf_latency%0d: got %0d expected 2", i, rec_latency); end
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;
    end
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_empty: got %0d expected 0", rec_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %0d expected 1", overflow); end
  endtask

  // Full FIFO with a simultaneous pop in the completion cycle: nothing lost
  task automatic test_full_push_pop();
    do_reset();
    for (int k = 0; k < 9; k++) begin
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0; ap_done = 1'b1;
      rec_ready = (k == 8);
      tick();
      ap_done = 1'b0; rec_ready = 1'b0;
    end
    checks++; if (drop_cnt !== 32'd0) begin errors++; $display("[TB] FAIL fpp_drop_cnt: got %0d expected 0", drop_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fpp_overflow: got %0d expected 0", overflow); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (rec_id !== 16'(i)) begin errors++; $display("[TB] FAIL fpp_id%0d: got %0d expected %0d", i, rec_id, i); end
      checks++; if (rec_start_cyc !== 32'(2 * i)) begin errors++; $display("[TB] FAIL fpp_start%0d: got %0d expected %0d", i, rec_start_cyc, 2 * i); end
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;
    end
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("[TB] FAIL fpp_empty: got %0d expected 0", rec_valid); end
  endtask

  // ap_done with ap_continue low: HOLD cycles excluded, ap_start blocked
  task automatic test_hold();
    do_reset();
    ap_start = 1'b1; pipe_stall = 1'b1;                  // cycle 0
    tick();
    ap_start = 1'b0; pipe_stall = 1'b0; iter_end = 1'b1; // cycle 1
    tick();
    ap_done = 1'b1; ap_continue = 1'b0;                  // cycle 2
    tick();
    ap_done = 1'b0; ap_start = 1'b1; pipe_stall = 1'b1;  // cycles 3..4 HOLD
    checks++; if (rec_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid: got %0d expected 1", rec_valid); end
    checks++; if (rec_latency !== 32'd3) begin errors++; $display("[TB] FAIL hold_latency: got %0d expected 3", rec_latency); end
    checks++; if (rec_iters !== 32'd2) begin errors++; $display("[TB] FAIL hold_iters: got %0d expected 2", rec_iters); end
    checks++; if (rec_stalls !== 32'd1) begin errors++; $display("[TB] FAIL hold_stalls: got %0d expected 1", rec_stalls); end
    for (int c = 3; c <= 5; c++) begin
      ap_continue = (c == 5);
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL hold_busy_c%0d: got %0d expected 1", c, busy); end
      tick();
    end
    iter_end = 1'b0; pipe_stall = 1'b0;                  // cycle 6, IDLE
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL hold_idle: got %0d expected 0", busy); end
    tick();
    ap_start = 1'b0; ap_done = 1'b1;                     // cycle 7
    tick();
    ap_done = 1'b0;
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    checks++; if (rec_id !== 16'd1) begin errors++; $display("[TB] FAIL hold_next_id: got %0d expected 1", rec_id); end
    checks++; if (rec_start_cyc !== 32'd6) begin errors++; $display("[TB] FAIL hold_next_start: got %0d expected 6", rec_start_cyc); end
    checks++; if (rec_latency !== 32'd2) begin errors++; $display("[TB] FAIL hold_next_latency: got %0d expected 2", rec_latency); end
    checks++; if (rec_iters !== 32'd0) begin errors++; $display("[TB] FAIL hold_next_iters: got %0d expected 0", rec_iters); end
    checks++; if (rec_stalls !== 32'd0) begin errors++; $display("[TB] FAIL hold_next_stalls: got %0d expected 0", rec_stalls); end
  endtask

  // Reset during RUN discards the partial record and restarts id and counter
  task automatic test_reset_mid_run();
    do_reset();
    repeat (2) tick();
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0; iter_end = 1'b1;
    repeat (2) tick();
    reset = 1'b1; ap_done = 1'b1;
    tick();
    reset = 1'b0; ap_done = 1'b0; iter_end = 1'b0;
    checks++; if (rec_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_run_valid: got %0d expected 0", rec_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_run_busy: got %0d expected 0", busy); end
    repeat (3) tick();
    ap_start = 1'b1; ap_done = 1'b1;
    tick();
    ap_start = 1'b0; ap_done = 1'b0;
    checks++; if (rec_id !== 16'd0) begin errors++; $display("[TB] FAIL rst_run_id: got %0d expected 0", rec_id); end
    checks++; if (rec_start_cyc !== 32'd3) begin errors++; $display("[TB] FAIL rst_run_start: got %0d expected 3", rec_start_cyc); end
    checks++; if (rec_latency !== 32'd1) begin errors++; $display("[TB] FAIL rst_run_latency: got %0d expected 1", rec_latency); end
  endtask

  // Scenario sequence and summary
  initial begin
    test_reset();
    test_basic();
    test_start_done_same();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_hold();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
